// File: rtl/bcd_pkg.sv
// -----------------------------------------------------------------------------
// bcd_pkg
// Shared types and constants for the handshake binary-to-BCD converter.
//   bcd_state_t      : converter control states (IDLE / CONVERT / DONE)
//   BCD_BLANK_NIBBLE : code for a blanked leading-zero digit
//   clog2()          : ceiling log2, used to size the iteration counter
// -----------------------------------------------------------------------------
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    DONE    = 2'd2
  } bcd_state_t;

  localparam logic [3:0] BCD_BLANK_NIBBLE = 4'hF;

  // Evaluated at elaboration time only; matches $clog2 for value >= 1.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result++;
    end
    return result;
  endfunction

endpackage : bcd_pkg

// File: rtl/bcd_digit_adjust.sv
// -----------------------------------------------------------------------------
// bcd_digit_adjust
// Double-dabble correction for a single BCD digit: any digit of 5 or more is
// pre-biased by +3 so the following left shift carries correctly into the next
// decimal digit. Purely combinational.
//   i_Digit [3:0] : digit before correction
//   o_Digit [3:0] : corrected digit (4-bit wrap)
// -----------------------------------------------------------------------------
module bcd_digit_adjust (
  input  logic [3:0] i_Digit,
  output logic [3:0] o_Digit
);

  assign o_Digit = (i_Digit >= 4'd5) ? (i_Digit + 4'd3) : i_Digit;

endmodule : bcd_digit_adjust

// File: rtl/binary_to_bcd_hs.sv
// -----------------------------------------------------------------------------
// binary_to_bcd_hs
// Iterative double-dabble binary-to-BCD converter with ready/valid handshakes
// on input and output, optional two's-complement input and overflow flagging.
// One bit is consumed per cycle; a result appears INPUT_WIDTH cycles after the
// input word is accepted and is held until the downstream side takes it.
//
// Parameters
//   INPUT_WIDTH    : binary input width (2..64)
//   DECIMAL_DIGITS : number of BCD output digits (1..20)
//
// Ports
//   i_Clock     : clock, rising edge
//   i_Reset_n   : asynchronous active-low reset
//   i_Valid     : input word valid
//   o_Ready     : converter can accept an input word (IDLE only)
//   i_Binary    : value to convert
//   i_Signed    : treat i_Binary as two's complement
//   o_Valid     : result valid, held until accepted
//   i_Ready     : downstream accepts the result
//   o_BCD       : packed BCD digits, digit 0 in bits [3:0]
//   o_Neg       : result is negative
//   o_Overflow  : magnitude did not fit; o_BCD holds the low digits only
//
// Build option
//   BIN_BCD_BLANK_EN : when defined, leading zero digits above digit 0 are
//                      replaced by BCD_BLANK_NIBBLE on non-overflowed results.
// -----------------------------------------------------------------------------
module binary_to_bcd_hs
  import bcd_pkg::*;
#(
  parameter int INPUT_WIDTH    = 16,
  parameter int DECIMAL_DIGITS = 5
) (
  input  logic                        i_Clock,
  input  logic                        i_Reset_n,
  input  logic                        i_Valid,
  output logic                        o_Ready,
  input  logic [INPUT_WIDTH-1:0]      i_Binary,
  input  logic                        i_Signed,
  output logic                        o_Valid,
  input  logic                        i_Ready,
  output logic [DECIMAL_DIGITS*4-1:0] o_BCD,
  output logic                        o_Neg,
  output logic                        o_Overflow
);

  localparam int               BCD_W    = DECIMAL_DIGITS * 4;
  localparam int               CNT_W    = clog2(INPUT_WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(INPUT_WIDTH - 1);

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  bcd_state_t             r_state;
  logic [INPUT_WIDTH-1:0] r_mag;
  logic [BCD_W-1:0]       r_acc;
  logic                   r_neg;
  logic                   r_ovf;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_valid;
  logic [BCD_W-1:0]       r_bcd;
  logic                   r_out_neg;
  logic                   r_out_ovf;

  bcd_state_t             w_state_next;
  logic                   w_ready;
  logic                   w_in_neg;
  logic [INPUT_WIDTH-1:0] w_in_mag;
  logic [BCD_W-1:0]       w_adj;
  logic [BCD_W-1:0]       w_acc_next;
  logic                   w_ovf_next;
  logic                   w_last;
  logic [BCD_W-1:0]       w_bcd_out;

  // ---------------------------------------------------------------------------
  // Input magnitude. The negate is done at INPUT_WIDTH bits and read as
  // unsigned, so the most negative input lands exactly on 2^(W-1).
  // ---------------------------------------------------------------------------
  assign w_in_neg = i_Signed && i_Binary[INPUT_WIDTH-1];
  assign w_in_mag = w_in_neg ? (~i_Binary + INPUT_WIDTH'(1)) : i_Binary;

  // ---------------------------------------------------------------------------
  // One double-dabble iteration: correct every digit in parallel, then shift
  // the next magnitude bit in. The bit leaving the top digit means the value
  // no longer fits in DECIMAL_DIGITS; it is dropped and remembered in r_ovf,
  // leaving the accumulator holding the value modulo 10^DECIMAL_DIGITS.
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < DECIMAL_DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .i_Digit (r_acc[g*4 +: 4]),
      .o_Digit (w_adj[g*4 +: 4])
    );
  end

  assign w_acc_next = {w_adj[BCD_W-2:0], r_mag[INPUT_WIDTH-1]};
  assign w_ovf_next = r_ovf | w_adj[BCD_W-1];
  assign w_last     = (r_cnt == LAST_CNT);

  // ---------------------------------------------------------------------------
  // Presentation of the finished accumulator (optional leading-zero blanking)
  // ---------------------------------------------------------------------------
`ifdef BIN_BCD_BLANK_EN
  logic w_blank_run;

  always_comb begin
    // NOTE: every signal written here gets a value before any condition, so
    // no path leaves it unassigned and no latch is inferred.
    w_bcd_out   = w_acc_next;
    w_blank_run = !w_ovf_next;
    for (int d = DECIMAL_DIGITS - 1; d >= 1; d--) begin
      if (w_blank_run && (w_acc_next[d*4 +: 4] == 4'd0)) begin
        w_bcd_out[d*4 +: 4] = BCD_BLANK_NIBBLE;
      end else begin
        w_blank_run = 1'b0;
      end
    end
  end
`else
  assign w_bcd_out = w_acc_next;
`endif

  // ---------------------------------------------------------------------------
  // Control FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      r_state <= IDLE;
    end else begin
      // NOTE: clocked state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM: next state and ready
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_ready      = 1'b0;
    case (r_state)
      IDLE: begin
        w_ready = 1'b1;
        if (i_Valid) w_state_next = CONVERT;
      end
      CONVERT: begin
        if (w_last) w_state_next = DONE;
      end
      DONE: begin
        if (i_Ready) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      // NOTE: the working registers are reset too, so an aborted conversion
      // leaves nothing behind and the outputs restart from zero.
      r_mag     <= '0;
      r_acc     <= '0;
      r_neg     <= 1'b0;
      r_ovf     <= 1'b0;
      r_cnt     <= '0;
      r_valid   <= 1'b0;
      r_bcd     <= '0;
      r_out_neg <= 1'b0;
      r_out_ovf <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_Valid) begin
            r_mag <= w_in_mag;
            r_acc <= '0;
            r_neg <= w_in_neg;
            r_ovf <= 1'b0;
            r_cnt <= '0;
          end
        end
        CONVERT: begin
          r_acc <= w_acc_next;
          r_mag <= {r_mag[INPUT_WIDTH-2:0], 1'b0};
          r_ovf <= w_ovf_next;
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_valid   <= 1'b1;
            r_bcd     <= w_bcd_out;
            r_out_neg <= r_neg;
            r_out_ovf <= w_ovf_next;
          end
        end
        DONE: begin
          if (i_Ready) r_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign o_Ready    = w_ready;
  assign o_Valid    = r_valid;
  assign o_BCD      = r_bcd;
  assign o_Neg      = r_out_neg;
  assign o_Overflow = r_out_ovf;

endmodule : binary_to_bcd_hs

// File: tb/tb_binary_to_bcd_hs.sv
// -----------------------------------------------------------------------------
// tb_binary_to_bcd_hs
// Self-checking bench for binary_to_bcd_hs. Two instances share all inputs:
// u_dut5 uses the default 5 digits, u_dut4 uses 4 digits so overflow is
// exercised on the same stimulus. Expected results come from a decimal
// reference model (repeated division by ten). Honors BIN_BCD_BLANK_EN.
// -----------------------------------------------------------------------------
module tb_binary_to_bcd_hs;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_bin = '0;
  logic         in_signed = 1'b0;
  logic         out_ready = 1'b0;

  logic         ready_a, valid_a, neg_a, ovf_a;
  logic [19:0]  bcd_a;
  logic         ready_b, valid_b, neg_b, ovf_b;
  logic [15:0]  bcd_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  binary_to_bcd_hs #(.INPUT_WIDTH(W), .DECIMAL_DIGITS(5)) u_dut5 (
    .i_Clock(clk), .i_Reset_n(rst_n), .i_Valid(in_valid), .o_Ready(ready_a),
    .i_Binary(in_bin), .i_Signed(in_signed), .o_Valid(valid_a), .i_Ready(out_ready),
    .o_BCD(bcd_a), .o_Neg(neg_a), .o_Overflow(ovf_a)
  );

  binary_to_bcd_hs #(.INPUT_WIDTH(W), .DECIMAL_DIGITS(4)) u_dut4 (
    .i_Clock(clk), .i_Reset_n(rst_n), .i_Valid(in_valid), .o_Ready(ready_b),
    .i_Binary(in_bin), .i_Signed(in_signed), .o_Valid(valid_b), .i_Ready(out_ready),
    .o_BCD(bcd_b), .o_Neg(neg_b), .o_Overflow(ovf_b)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Decimal reference: digits by repeated division, overflow if anything is
  // left above the top digit, optional blanking of leading zeros.
  function automatic logic [19:0] ref_bcd(input longint unsigned mag, input int digits,
                                         output logic ovf);
    logic [19:0]     r;
    longint unsigned m;
    r = '0;
    m = mag;
    for (int d = 0; d < digits; d++) begin
      r[d*4 +: 4] = 4'(m % 10);
      m = m / 10;
    end
    ovf = (m != 0);
`ifdef BIN_BCD_BLANK_EN
    if (!ovf) begin
      for (int d = digits - 1; d >= 1; d--) begin
        if (r[d*4 +: 4] != 4'd0) break;
        r[d*4 +: 4] = 4'hF;
      end
    end
`endif
    return r;
  endfunction

  // One full transaction: accept, measure latency, check both instances,
  // optionally hold back-pressure for bp cycles, then complete the handshake.
  task automatic run_txn(input logic [W-1:0] value, input logic sgn, input int bp);
    longint unsigned mag;
    logic            neg, ovf5, ovf4;
    logic [19:0]     exp5, exp4;
    int              lat;

    for (int i = 0; i < 50 && !ready_a; i++) begin
      @(posedge clk); #1;
    end
    check("ready_idle", ready_a, 1);

    neg  = sgn && value[W-1];
    mag  = neg ? ((longint'(1) << W) - longint'(value)) : longint'(value);
    exp5 = ref_bcd(mag, 5, ovf5);
    exp4 = ref_bcd(mag, 4, ovf4);

    in_valid  = 1'b1;
    in_bin    = value;
    in_signed = sgn;
    out_ready = (bp == 0);
    @(posedge clk); #1;
    check("ready_busy", ready_a, 0);

    lat = 0;
    while (!valid_a && lat < W + 4) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_bin    = W'($urandom);
      in_signed = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    check("latency", lat, W);
    check("bcd5", bcd_a, exp5);
    check("neg5", neg_a, neg);
    check("ovf5", ovf_a, ovf5);
    check("valid4", valid_b, 1);
    check("bcd4", bcd_b, exp4[15:0]);
    check("neg4", neg_b, neg);
    check("ovf4", ovf_b, ovf4);

    for (int i = 0; i < bp; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_bin   = W'($urandom);
      @(posedge clk); #1;
      check("bp_valid", valid_a, 1);
      check("bp_bcd", bcd_a, exp5);
      check("bp_ready", ready_a, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("hs_valid", valid_a, 0);
    check("hs_ready", ready_a, 1);
    check("hs_hold", bcd_a, exp5);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] v;
    logic         s;
    int           bp;

    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", ready_a, 1);
    check("rst_valid", valid_a, 0);
    check("rst_bcd", bcd_a, 0);
    check("rst_neg", neg_a, 0);
    check("rst_ovf", ovf_a, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_txn(16'd65535, 1'b0, 0);

    // Reset during iteration 7 of a conversion aborts it.
    in_valid  = 1'b1;
    in_bin    = 16'd1234;
    in_signed = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_valid", valid_a, 0);
    check("abort_ready", ready_a, 1);
    check("abort_bcd5", bcd_a, 0);
    check("abort_bcd4", bcd_b, 0);
    check("abort_ovf4", ovf_b, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_txn(16'd1234, 1'b0, 0);

    run_txn(16'h8000, 1'b1, 0);
    run_txn(16'hFFFF, 1'b1, 0);
    run_txn(16'h0000, 1'b1, 0);
    run_txn(16'd12345, 1'b0, 0);
    run_txn(16'd9999, 1'b0, 0);
    run_txn(16'd42, 1'b0, 0);
    run_txn(16'd0, 1'b0, 0);
    run_txn(16'd10000, 1'b0, 0);
    run_txn(16'd7, 1'b0, 10);
    run_txn(16'h7FFF, 1'b1, 0);

    for (int n = 0; n < 150; n++) begin
      case ($urandom_range(0, 3))
        0:       v = W'($urandom_range(0, 20));
        1:       v = W'($urandom_range(9990, 10010));
        2:       v = W'($urandom_range(0, 1)) ? 16'h8000 : 16'hFFFF;
        default: v = W'($urandom);
      endcase
      s  = 1'($urandom_range(0, 1));
      bp = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 4) : 0;
      run_txn(v, s, bp);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
    $finish;
  end

endmodule : tb_binary_to_bcd_hs
